// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared state encoding, spacer length and default widths for the dsp sequencer
package dsp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_D,
        ACC_REQ,
        ACC_GAP,
        ACC_WAIT,
        ACC_IDLE,
        FIN
    } state_t;

    localparam int ACC_SPACER_CYCLES   = 3;
    localparam int DEF_BUS_WIDTH       = 32;
    localparam int DEF_ADDRESS_WIDTH   = 10;
    localparam int DEF_OUTPUT_WIDTH    = 32;

endpackage

// File: rtl/dsp_sequencer_if.sv
// rtl/dsp_sequencer_if.sv - core-side valid/ack bundle between the sequencer (master) and the dsp core (slave)
interface dsp_sequencer_if #(
    parameter int BUS_WIDTH    = 32,
    parameter int OUTPUT_WIDTH = 32
);
    logic                    spi_valid;
    logic [BUS_WIDTH-1:0]    spi_data;
    logic                    weight_ack;
    logic                    wish_valid;
    logic [BUS_WIDTH-1:0]    wish_data;
    logic                    data_ack;
    logic                    conv_ack;
    logic [OUTPUT_WIDTH-1:0] conv_data;

    modport master (
        output spi_valid, spi_data, wish_valid, wish_data,
        input  weight_ack, data_ack, conv_ack, conv_data
    );

    modport slave (
        input  spi_valid, spi_data, wish_valid, wish_data,
        output weight_ack, data_ack, conv_ack, conv_data
    );
endinterface

// File: rtl/dsp_xfer_counter.sv
// rtl/dsp_xfer_counter.sv - clearable, enabled up-counter flagging its final count (LIMIT-1)
module dsp_xfer_counter #(
    parameter int WIDTH = 11,
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign last = (count == WIDTH'(LIMIT - 1));
endmodule

// File: rtl/dsp_sequencer.sv
// rtl/dsp_sequencer.sv - weight/data loader and accumulate issuer for the dsp core; watchdog under DSP_SEQ_TIMEOUT_EN
module dsp_sequencer
    import dsp_pkg::*;
#(
    parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int OUTPUT_WIDTH  = DEF_OUTPUT_WIDTH
`ifdef DSP_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_START,
    input  logic [7:0]              i_NUM_PASSES,
    input  logic [BUS_WIDTH-1:0]    i_ACC_WORD,
    input  logic                    i_SRC_VALID,
    input  logic [BUS_WIDTH-1:0]    i_SRC_DATA,
    output logic                    o_SRC_READY,
    dsp_sequencer_if.master         core,
    output logic [OUTPUT_WIDTH-1:0] o_RESULT,
    output logic                    o_RESULT_VALID,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output logic                    o_TIMEOUT
);
    state_t               state, state_next;
    logic [7:0]           passes;
    logic [BUS_WIDTH-1:0] acc_word;
    logic                 beat, beat_last, spacer_last, wd_last, capture;

    dsp_xfer_counter #(.WIDTH(ADDRESS_WIDTH + 1), .LIMIT(2 ** ADDRESS_WIDTH)) u_beat (
        .clk(i_CLK), .rst(i_RST), .clear((state == IDLE) || (beat && beat_last)),
        .en(beat), .last(beat_last)
    );

    dsp_xfer_counter #(.WIDTH(2), .LIMIT(ACC_SPACER_CYCLES)) u_spacer (
        .clk(i_CLK), .rst(i_RST), .clear(state != ACC_IDLE),
        .en(state == ACC_IDLE), .last(spacer_last)
    );

`ifdef DSP_SEQ_TIMEOUT_EN
    dsp_xfer_counter #(.WIDTH($clog2(TIMEOUT_CYCLES) + 1), .LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk(i_CLK), .rst(i_RST), .clear(state != ACC_WAIT),
        .en(state == ACC_WAIT), .last(wd_last)
    );

    // Sticky until reset or the next accepted start.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            o_TIMEOUT <= 1'b0;
        end else if (state == IDLE && i_START) begin
            o_TIMEOUT <= 1'b0;
        end else if (state == ACC_WAIT && !core.conv_ack && wd_last) begin
            o_TIMEOUT <= 1'b1;
        end
    end
`else
    assign wd_last   = 1'b0;
    assign o_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state          <= IDLE;
            passes         <= 8'd0;
            acc_word       <= '0;
            o_RESULT       <= '0;
            o_RESULT_VALID <= 1'b0;
        end else begin
            state          <= state_next;
            o_RESULT_VALID <= capture;
            if (state == IDLE && i_START) begin
                passes   <= i_NUM_PASSES;
                acc_word <= i_ACC_WORD;
            end
            if (capture) begin
                o_RESULT <= core.conv_data;
                passes   <= passes - 8'd1;
            end
        end
    end

    assign o_BUSY = (state != IDLE);

    always_comb begin
        state_next      = state;
        beat            = 1'b0;
        capture         = 1'b0;
        o_SRC_READY     = 1'b0;
        o_DONE          = 1'b0;
        core.spi_valid  = 1'b0;
        core.spi_data   = '0;
        core.wish_valid = 1'b0;
        core.wish_data  = '0;
        case (state)
            IDLE: if (i_START) state_next = LOAD_W;
            LOAD_W: begin
                beat           = core.weight_ack & i_SRC_VALID;
                o_SRC_READY    = beat;
                core.spi_valid = beat;
                core.spi_data  = i_SRC_DATA;
                if (beat && beat_last) state_next = LOAD_D;
            end
            LOAD_D: begin
                beat            = core.data_ack & i_SRC_VALID;
                o_SRC_READY     = beat;
                core.wish_valid = beat;
                core.wish_data  = i_SRC_DATA;
                if (beat && beat_last) state_next = (passes == 8'd0) ? FIN : ACC_REQ;
            end
            ACC_REQ: begin
                core.wish_valid = 1'b1;
                core.wish_data  = acc_word;
                state_next      = ACC_GAP;
            end
            // An ack seen here belongs to the previous pass, so it is not looked at.
            ACC_GAP: state_next = ACC_WAIT;
            ACC_WAIT: begin
                if (core.conv_ack) begin
                    capture    = 1'b1;
                    state_next = (passes == 8'd1) ? FIN : ACC_IDLE;
                end else if (wd_last) begin
                    state_next = FIN;
                end
            end
            ACC_IDLE: if (spacer_last) state_next = ACC_REQ;
            FIN: begin
                o_DONE     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dsp_sequencer.sv
// tb/tb_dsp_sequencer.sv - directed self-checking bench for dsp_sequencer
module tb_dsp_sequencer;
    localparam int          BW   = 32;
    localparam int          AW   = 10;
    localparam int          OW   = 32;
    localparam int          NB   = 1024;
    localparam logic [31:0] BASE = 32'hA500_0000;

    logic        clk = 1'b0;
    logic        rst, start, src_valid, src_ready, result_valid, busy, done, timeout;
    logic [7:0]  num_passes;
    logic [31:0] acc_in, src_data, result, exp_acc;

    int tests = 0, fails = 0;
    int cyc = 0, spi_cnt, wl_cnt, acc_cnt, res_cnt, done_cnt, mon_err;
    int last_acc, ack_due, done_cyc, start_cyc, src_idx, ack_delay, exp_spacing;
    bit gaps = 0, ack_always = 0, ack_never = 0, taken;

    dsp_sequencer_if #(.BUS_WIDTH(BW), .OUTPUT_WIDTH(OW)) core ();

    dsp_sequencer #(
        .BUS_WIDTH(BW), .ADDRESS_WIDTH(AW), .OUTPUT_WIDTH(OW)
`ifdef DSP_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(64)
`endif
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_START(start), .i_NUM_PASSES(num_passes),
        .i_ACC_WORD(acc_in), .i_SRC_VALID(src_valid), .i_SRC_DATA(src_data),
        .o_SRC_READY(src_ready), .core(core.master), .o_RESULT(result),
        .o_RESULT_VALID(result_valid), .o_BUSY(busy), .o_DONE(done), .o_TIMEOUT(timeout)
    );

    always #5 clk = ~clk;

    // Source and core model, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (taken) src_idx++;
        taken           = 1'b0;
        src_valid       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        src_data        = BASE + 32'(src_idx);
        core.weight_ack = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        core.data_ack   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        core.conv_ack   = ack_always || (!ack_never && cyc == ack_due);
        core.conv_data  = ack_always ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(acc_cnt);
    end

    // Protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        bit wbeat;
        wbeat = 1'b0;
        if (core.spi_valid === 1'b1) begin
            if (core.spi_data !== BASE + 32'(spi_cnt) || !core.weight_ack || !src_valid) mon_err++;
            spi_cnt++;
        end
        if (core.wish_valid === 1'b1) begin
            if (wl_cnt < NB) begin
                if (core.wish_data !== BASE + 32'(NB + wl_cnt) || !core.data_ack || !src_valid) mon_err++;
                wl_cnt++;
                wbeat = 1'b1;
            end else begin
                if (core.wish_data !== exp_acc) mon_err++;
                if (acc_cnt > 0 && cyc - last_acc != exp_spacing) mon_err++;
                last_acc = cyc;
                acc_cnt++;
                ack_due = cyc + ack_delay;
            end
        end
        if (src_ready !== ((core.spi_valid === 1'b1) || wbeat)) mon_err++;
        if (src_ready === 1'b1) taken = 1'b1;
        if (result_valid === 1'b1) begin
            res_cnt++;
            if (result !== (ack_always ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(acc_cnt))) mon_err++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        spi_cnt = 0; wl_cnt = 0; acc_cnt = 0; res_cnt = 0; done_cnt = 0; mon_err = 0;
        last_acc = 0; ack_due = -1; done_cyc = 0; src_idx = 0; taken = 1'b0;
    endtask

    task automatic start_run(input int p, input logic [31:0] acc);
        clear_mon();
        num_passes = 8'(p);
        acc_in     = acc;
        exp_acc    = acc;
        start_cyc  = cyc;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done_cnt > 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (spi_cnt < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat", 32'(spi_cnt >= target), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_passes = 8'd0; acc_in = '0; exp_acc = '0;
        ack_delay = 20; exp_spacing = 24;
        clear_mon();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rvalid", 32'(result_valid), 32'd0);
        check("rst_valids", 32'({core.spi_valid, core.wish_valid, src_ready}), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Four passes, ack 20 cycles after each accumulate strobe.
        start_run(4, 32'h3);
        wait_done("full_done", 6000);
        check("full_spi", spi_cnt, NB);
        check("full_wish", wl_cnt, NB);
        check("full_acc", acc_cnt, 4);
        check("full_res", res_cnt, 4);
        check("full_done_cnt", done_cnt, 1);
        check("full_latency", done_cyc - start_cyc, 2142);
        check("full_result", result, 32'hC0DE_0004);
        check("full_mon", mon_err, 0);
        check("full_idle", 32'(busy), 32'd0);

        // Random backpressure on both acks and the source.
        gaps = 1; ack_delay = 5; exp_spacing = 9;
        start_run(2, 32'h55AA);
        wait_done("bp_done", 20000);
        gaps = 0;
        check("bp_spi", spi_cnt, NB);
        check("bp_wish", wl_cnt, NB);
        check("bp_acc", acc_cnt, 2);
        check("bp_result", result, 32'hC0DE_0002);
        check("bp_mon", mon_err, 0);

        // Zero passes: load only.
        start_run(0, 32'h9);
        wait_done("zero_done", 4000);
        check("zero_acc", acc_cnt, 0);
        check("zero_res", res_cnt, 0);
        check("zero_latency", done_cyc - start_cyc, 2049);
        check("zero_mon", mon_err, 0);

        // Conversion ack stuck high.
        ack_always = 1; exp_spacing = 6;
        start_run(3, 32'h77);
        wait_done("stuck_done", 4000);
        ack_always = 0;
        check("stuck_acc", acc_cnt, 3);
        check("stuck_res", res_cnt, 3);
        check("stuck_result", result, 32'hDEAD_BEEF);
        check("stuck_mon", mon_err, 0);

        // Reset in the middle of the weight load, then a clean run with a stray start.
        ack_delay = 20; exp_spacing = 24;
        start_run(2, 32'h11);
        wait_beats(500);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valids", 32'({core.spi_valid, core.wish_valid, src_ready}), 32'd0);
        check("mid_rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        start_run(1, 32'h22);
        wait_beats(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("restart_done", 4000);
        check("restart_spi", spi_cnt, NB);
        check("restart_wish", wl_cnt, NB);
        check("restart_acc", acc_cnt, 1);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_mon", mon_err, 0);

        // Core never acknowledges.
        ack_never = 1;
        start_run(2, 32'h33);
`ifdef DSP_SEQ_TIMEOUT_EN
        wait_done("wd_done", 4000);
        check("wd_flag", 32'(timeout), 32'd1);
        check("wd_delay", done_cyc - last_acc, 66);
        check("wd_acc", acc_cnt, 1);
        check("wd_res", res_cnt, 0);
        check("wd_result", result, 32'hC0DE_0001);
        start_run(0, 32'h0);
        check("wd_clear", 32'(timeout), 32'd0);
        wait_done("wd_after_done", 4000);
`else
        repeat (2300) @(negedge clk);
        check("hang_busy", 32'(busy), 32'd1);
        check("hang_timeout", 32'(timeout), 32'd0);
        check("hang_done", done_cnt, 0);
        check("hang_acc", acc_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        ack_never = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dsp_sequencer.md
Name: dsp_sequencer

Overview:
Host-side initiator for the dsp core's valid/ack load-and-convolve protocol. Takes a word stream and fills the core's weight memory over the SPI-side port and its data memory over the Wishbone-side port. It then issues N accumulate commands, waits for o_CONV_ACK after each one, and captures each result. It sits between the SoC-facing register/stream logic and the dsp core, replacing software-driven handshaking.

Parameters:
BUS_WIDTH, 32, width of load/command words
ADDRESS_WIDTH, 10, log2 of memory depth; each load phase transfers 2**ADDRESS_WIDTH words
OUTPUT_WIDTH, 32, width of convolution result
TIMEOUT_CYCLES, 4096, watchdog limit per accumulate wait (optional feature only)

Ports:
i_CLK  in  1  clock
i_RST  in  1  synchronous, active-high reset
i_START  in  1  one-cycle start request
i_NUM_PASSES  in  8  accumulate passes; sampled at start
i_ACC_WORD  in  BUS_WIDTH  accumulate command word; sampled at start
i_SRC_VALID  in  1  source word available
i_SRC_DATA  in  BUS_WIDTH  source word (all weights first, then all data)
o_SRC_READY  out  1  source word consumed this cycle
o_SPI_VALID  out  1  weight write strobe to core
o_SPI_DATA  out  BUS_WIDTH  weight word to core
i_WEIGHT_ACK  in  1  core ready for weight word
o_WISH_VALID  out  1  data write / accumulate strobe to core
o_WISH_DATA  out  BUS_WIDTH  data word or accumulate word
i_DATA_ACK  in  1  core ready for data word
i_CONV_ACK  in  1  core convolution complete
i_CONV_DATA  in  OUTPUT_WIDTH  core result
o_RESULT  out  OUTPUT_WIDTH  last captured result
o_RESULT_VALID  out  1  one-cycle pulse per captured result
o_BUSY  out  1  high whenever state is not IDLE
o_DONE  out  1  one-cycle completion pulse
o_TIMEOUT  out  1  sticky watchdog flag (tied 0 when feature is compiled out)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, o_RESULT 0. Reset mid-operation aborts immediately; the core is left partially loaded.
- Single clock. The transfer counter is ADDRESS_WIDTH+1 bits wide. Nothing is clamped; the counter terminates at 2**ADDRESS_WIDTH.
- States:
  - IDLE: i_START captures i_NUM_PASSES and i_ACC_WORD, then goes to LOAD_W.
  - LOAD_W: o_SPI_VALID = o_SRC_READY = i_WEIGHT_ACK & i_SRC_VALID (combinational). o_SPI_DATA = i_SRC_DATA. Each beat increments the count. The last beat goes to LOAD_D with the count cleared.
  - LOAD_D: same as LOAD_W, but uses i_DATA_ACK, o_WISH_VALID and o_WISH_DATA. The last beat goes to ACC_REQ, or to FIN if passes==0.
  - ACC_REQ: o_WISH_VALID=1 and o_WISH_DATA=acc word for exactly one cycle, with no ack required. Then goes to ACC_GAP.
  - ACC_GAP: one cycle with valid low. i_CONV_ACK is ignored here (it is a stale ack from the previous pass). Then goes to ACC_WAIT.
  - ACC_WAIT: on i_CONV_ACK, register o_RESULT <= i_CONV_DATA, pulse o_RESULT_VALID on the next cycle, and decrement passes. If passes remain, go to ACC_IDLE; else go to FIN.
  - ACC_IDLE: 3-cycle spacer, then ACC_REQ.
  - FIN: o_DONE=1 for one cycle, then IDLE.
- Stalls: source valid low or ack low leaves valid low and holds the count; there is no bubble penalty.
- Valid is never asserted in any state other than these: LOAD_W (SPI), LOAD_D/ACC_REQ (WISH).
- i_START while busy is ignored. i_START in the same cycle as i_RST: reset wins.
- Latency: minimum 2*2**ADDRESS_WIDTH load cycles + per pass (1+1+ack wait+3) + 1.

Optional Feature:
Macro DSP_SEQ_TIMEOUT_EN.
- Defined: a watchdog counts cycles in ACC_WAIT and is cleared on entry. On reaching TIMEOUT_CYCLES it sets sticky o_TIMEOUT (cleared by reset or the next i_START), skips the remaining passes, and goes to FIN. o_RESULT is unchanged.
- Undefined: no counter is present, o_TIMEOUT = 0, and ACC_WAIT waits indefinitely.

Decomposition:
- dsp_pkg: state enum (IDLE, LOAD_W, LOAD_D, ACC_REQ, ACC_GAP, ACC_WAIT, ACC_IDLE, FIN), ACC_SPACER_CYCLES=3, default widths.
- One sub-module, dsp_xfer_counter: a clearable, enabled up-counter with a terminal-count output, parameterised by width and limit. It is reused for the beat count, the spacer and the watchdog.

Test Plan:
- Full run, ADDRESS_WIDTH=10, acks always high, source always valid (weights 0x1, data 0x2), passes=4, acc word 0x3, core model acks 20 cycles after each command:
  - expect 1024 SPI beats then 1024 WISH beats, each with data correct;
  - exactly 4 single-cycle WISH pulses carrying 0x3, spaced by ack + 5 cycles;
  - 4 o_RESULT_VALID pulses, then one o_DONE.
- Backpressure: i_WEIGHT_ACK/i_DATA_ACK toggled pseudo-randomly and source gaps inserted -> exactly 1024 beats per phase, no valid without ack, no duplicated or dropped source words.
- passes=0 -> after 2048 load beats, o_DONE pulses with no accumulate strobe and no o_RESULT_VALID.
- i_CONV_ACK held high continuously -> ACC_GAP ignores it; each pass still waits the full 1+1+1 cycles and captures i_CONV_DATA=0xDEADBEEF.
- Reset asserted at load beat 500, then restart -> outputs 0 the cycle after reset; the new run counts from beat 0 to 1024. i_START pulsed while busy has no effect.
- With DSP_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, core never acks -> o_TIMEOUT set after 64 wait cycles, then o_DONE. Without the macro -> o_TIMEOUT stays 0 and o_BUSY stays high.
